// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: fetches one 13-bit configuration word per pad, shifts the
// words MSB-first into the pad-ring chain using a divided serial_clock, then
// strobes serial_load so all pads latch together.
// Optional feature macro GPIO_SERIAL_RESET_EN: pulse serial_resetn low for
// 2*CLK_DIV cycles before shifting, returning the chain to its mask defaults.
//
// state  | meaning
// IDLE   | waiting for start
// RESET  | serial_resetn held low (GPIO_SERIAL_RESET_EN only)
// FETCH  | word_addr presented, word_data captured at end of cycle
// SHIFT  | low/high serial_clock phases, one bit per 2*CLK_DIV cycles
// LOAD   | serial_load high for CLK_DIV cycles
// DONE   | one-cycle done pulse, busy still high
module gpio_serial_loader #(
  parameter int NUM_GPIO = 19,
  parameter int CLK_DIV  = 2,
  localparam int AW = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] word_addr,
  input  logic [12:0]   word_data,
  output logic          serial_clock,
  output logic          serial_data,
  output logic          serial_load,
  output logic          serial_resetn
);

`ifdef GPIO_SERIAL_RESET_EN
  localparam int CW = $clog2(2 * CLK_DIV + 1);
`else
  localparam int CW = $clog2(CLK_DIV + 1);
`endif
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef GPIO_SERIAL_RESET_EN
    ST_RESET,
`endif
    ST_FETCH,
    ST_SHIFT,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   div_cnt, div_cnt_n;
  logic            phase, phase_n;        // 0 = low phase, 1 = high phase
  logic [3:0]      bit_cnt, bit_cnt_n;
  // serial_data holds the current MSB; shreg holds the 12 bits still to go.
  logic [11:0]     shreg, shreg_n;
  logic            busy_n, done_n, serial_clock_n, serial_data_n, serial_load_n;
  logic [AW-1:0]   word_addr_n;
`ifdef GPIO_SERIAL_RESET_EN
  logic            resetn_q, resetn_n;
  assign serial_resetn = resetn_q;
`else
  assign serial_resetn = 1'b1;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n        = state;
    div_cnt_n      = div_cnt;
    phase_n        = phase;
    bit_cnt_n      = bit_cnt;
    shreg_n        = shreg;
    busy_n         = busy;
    done_n         = done;
    word_addr_n    = word_addr;
    serial_clock_n = serial_clock;
    serial_data_n  = serial_data;
    serial_load_n  = serial_load;
`ifdef GPIO_SERIAL_RESET_EN
    resetn_n       = resetn_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          busy_n      = 1'b1;
          word_addr_n = AW'(NUM_GPIO - 1);
`ifdef GPIO_SERIAL_RESET_EN
          state_n     = ST_RESET;
          div_cnt_n   = CW'(2 * CLK_DIV - 1);
          resetn_n    = 1'b0;
`else
          state_n     = ST_FETCH;
`endif
        end
      end
`ifdef GPIO_SERIAL_RESET_EN
      ST_RESET: begin
        if (div_cnt == '0) begin
          resetn_n = 1'b1;
          state_n  = ST_FETCH;
        end else begin
          div_cnt_n = div_cnt - CW'(1);
        end
      end
`endif
      ST_FETCH: begin
        serial_data_n = word_data[12];
        shreg_n       = word_data[11:0];
        bit_cnt_n     = 4'd12;
        phase_n       = 1'b0;
        div_cnt_n     = DIV_LAST;
        state_n       = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_cnt != '0) begin
          div_cnt_n = div_cnt - CW'(1);
        end else if (!phase) begin
          phase_n        = 1'b1;
          serial_clock_n = 1'b1;
          div_cnt_n      = DIV_LAST;
        end else begin
          serial_clock_n = 1'b0;
          phase_n        = 1'b0;
          div_cnt_n      = DIV_LAST;
          shreg_n        = {shreg[10:0], 1'b0};
          if (bit_cnt != 4'd0) begin
            bit_cnt_n     = bit_cnt - 4'd1;
            serial_data_n = shreg[11];
          end else if (word_addr == '0) begin
            serial_load_n = 1'b1;
            state_n       = ST_LOAD;
          end else begin
            word_addr_n = word_addr - AW'(1);
            state_n     = ST_FETCH;
          end
        end
      end
      ST_LOAD: begin
        if (div_cnt == '0) begin
          serial_load_n = 1'b0;
          done_n        = 1'b1;
          state_n       = ST_DONE;
        end else begin
          div_cnt_n = div_cnt - CW'(1);
        end
      end
      ST_DONE: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      phase        <= 1'b0;
      bit_cnt      <= 4'd0;
      shreg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      word_addr    <= '0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
`ifdef GPIO_SERIAL_RESET_EN
      resetn_q     <= 1'b1;
`endif
    end else begin
      state        <= state_n;
      div_cnt      <= div_cnt_n;
      phase        <= phase_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      busy         <= busy_n;
      done         <= done_n;
      word_addr    <= word_addr_n;
      serial_clock <= serial_clock_n;
      serial_data  <= serial_data_n;
      serial_load  <= serial_load_n;
`ifdef GPIO_SERIAL_RESET_EN
      resetn_q     <= resetn_n;
`endif
    end
  end

endmodule
